// File: rtl/decode_pkg.sv
// Decode stage shared definitions: instruction field positions, default
// widths, link register index and the ID/EX payload layout.
package decode_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_REG_N    = 32;
   localparam int unsigned DEF_REG_AW   = $clog2(DEF_REG_N);
   localparam int unsigned DEF_IMM_W    = 16;
   localparam int unsigned DEF_LINK_REG = 31;

   // Register field LSB positions within the 32-bit instruction word
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_LSB = 16;
   localparam int unsigned RD_LSB = 11;

   // ID/EX pipeline register payload (sized for the default configuration)
   typedef struct packed {
      logic [DEF_DATA_W-1:0] rs_data;
      logic [DEF_DATA_W-1:0] rt_data;
      logic [DEF_DATA_W-1:0] imm_ext;
      logic [DEF_DATA_W-1:0] link_data;
      logic [DEF_REG_AW-1:0] dest;
      logic                  dest_we;
   } id_ex_t;

endpackage

// File: rtl/reg_file.sv
// Register file: REG_N x DATA_W, two asynchronous read ports, one synchronous
// write port, synchronous active-low clear. Register 0 is hardwired to zero.
// Ports: clk, rst (sync, active-low), we/waddr/wdata (write),
//        raddr0/rdata0 and raddr1/rdata1 (combinational reads).
module reg_file #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_N  = 32,
   parameter int unsigned REG_AW = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1
);

   logic [DATA_W-1:0] regs [REG_N];

   // Storage: clear on reset, writes to register 0 are dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(REG_N); i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: register 0 always reads zero
   always_comb begin
      rdata0 = (raddr0 == '0) ? '0 : regs[raddr0];
      rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   end

endmodule

// File: rtl/pipelined_decode_stage.sv
// Decode stage with register file, operand read, immediate extension,
// destination select and an ID/EX register with valid/ready handshake and
// load-use hazard stall.
// Build option: DECODE_BYPASS_EN forwards same-cycle write-back data into the
// captured operands; without it, a write-back to a source register stalls
// decode for one cycle so the operand is read after the write lands.
// Ports: clk, rst (sync, active-low); upstream in_valid/in_ready/instruction/
//        pc_plus_4 and decoded controls; write-back wb_en/wb_addr/wb_data;
//        EX load info ex_mem_read/ex_rt; downstream out_valid/out_ready and
//        payload rs_data, rt_data, imm_ext, link_data, dest, dest_we.
module pipelined_decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned REG_N    = DEF_REG_N,
   parameter int unsigned IMM_W    = DEF_IMM_W,
   parameter int unsigned LINK_REG = DEF_LINK_REG,
   localparam int unsigned REG_AW  = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc_plus_4,
   input  logic              jal,
   input  logic              reg_dst,
   input  logic              reg_write,
   input  logic              imm_signed,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] imm_ext,
   output logic [DATA_W-1:0] link_data,
   output logic [REG_AW-1:0] dest,
   output logic              dest_we
);

   logic [REG_AW-1:0] rs, rt, rd;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val;
   logic              hazard, wb_rs_hit, wb_rt_hit, accept;
   logic              unused_opcode;
   id_ex_t            id_ex, id_ex_nxt;

   assign rs  = instruction[RS_LSB +: REG_AW];
   assign rt  = instruction[RT_LSB +: REG_AW];
   assign rd  = instruction[RD_LSB +: REG_AW];
   assign imm = instruction[IMM_W-1:0];
   assign unused_opcode = ^instruction[31:26];

   reg_file #(
      .DATA_W (DATA_W),
      .REG_N  (REG_N),
      .REG_AW (REG_AW)
   ) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr0 (rs),
      .rdata0 (rf_rs),
      .raddr1 (rt),
      .rdata1 (rf_rt)
   );

   assign wb_rs_hit = wb_en && (wb_addr != '0) && (wb_addr == rs);
   assign wb_rt_hit = wb_en && (wb_addr != '0) && (wb_addr == rt);
   assign hazard    = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));

`ifdef DECODE_BYPASS_EN
   // Same-cycle write-back forwarded into the captured operands
   assign rs_val   = wb_rs_hit ? wb_data : rf_rs;
   assign rt_val   = wb_rt_hit ? wb_data : rf_rt;
   assign in_ready = (!out_valid || out_ready) && !hazard;
`else
   // Hold decode one cycle so the operand is read after the write lands
   assign rs_val   = rf_rs;
   assign rt_val   = rf_rt;
   assign in_ready = (!out_valid || out_ready) && !hazard && !(wb_rs_hit || wb_rt_hit);
`endif

   assign accept = in_valid && in_ready;

   // Next ID/EX payload from the instruction currently presented
   always_comb begin
      id_ex_nxt           = '0;
      id_ex_nxt.rs_data   = DEF_DATA_W'(rs_val);
      id_ex_nxt.rt_data   = DEF_DATA_W'(rt_val);
      id_ex_nxt.imm_ext   = imm_signed ? DEF_DATA_W'({{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm})
                                       : DEF_DATA_W'({{(DATA_W-IMM_W){1'b0}}, imm});
      id_ex_nxt.link_data = DEF_DATA_W'(pc_plus_4);
      id_ex_nxt.dest      = jal ? DEF_REG_AW'(LINK_REG) : DEF_REG_AW'(reg_dst ? rd : rt);
      id_ex_nxt.dest_we   = jal | reg_write;
   end

   // ID/EX register: load on accept, bubble when consumed without refill
   always_ff @(posedge clk) begin
      if (!rst) begin
         id_ex     <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         id_ex     <= id_ex_nxt;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign rs_data   = DATA_W'(id_ex.rs_data);
   assign rt_data   = DATA_W'(id_ex.rt_data);
   assign imm_ext   = DATA_W'(id_ex.imm_ext);
   assign link_data = DATA_W'(id_ex.link_data);
   assign dest      = REG_AW'(id_ex.dest);
   assign dest_we   = id_ex.dest_we;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed self-checking bench for pipelined_decode_stage.
module tb_pipelined_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc_plus_4;
   logic        jal, reg_dst, reg_write, imm_signed;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rs_data, rt_data, imm_ext, link_data;
   logic [4:0]  dest;
   logic        dest_we;

   int checks = 0;
   int errors = 0;

   pipelined_decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .pc_plus_4   (pc_plus_4),
      .jal         (jal),
      .reg_dst     (reg_dst),
      .reg_write   (reg_write),
      .imm_signed  (imm_signed),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .imm_ext     (imm_ext),
      .link_data   (link_data),
      .dest        (dest),
      .dest_we     (dest_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {6'd0, rs, rt, imm};
   endfunction

   logic [31:0] held_rs;

   initial begin
      rst = 1'b0; in_valid = 1'b0; instruction = '0; pc_plus_4 = '0;
      jal = 1'b0; reg_dst = 1'b0; reg_write = 1'b0; imm_signed = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rt = '0;
      out_ready = 1'b1;

      // Reset for two cycles
      tick(); tick();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_rs_data", rs_data, 32'd0);
      check("reset_dest_we", 32'(dest_we), 32'd0);
      rst = 1'b1;

      // Read r5 after reset
      in_valid = 1'b1; instruction = mk(5'd5, 5'd0, 16'h0000);
      #1;
      check("r5_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("r5_out_valid", 32'(out_valid), 32'd1);
      check("r5_rs_data", rs_data, 32'd0);

      // Write r3, then decode rs=3, rt=0
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
      tick();
      check("bubble_out_valid", 32'(out_valid), 32'd0);
      wb_en = 1'b0; in_valid = 1'b1; instruction = mk(5'd3, 5'd0, 16'h0000);
      tick();
      check("r3_out_valid", 32'(out_valid), 32'd1);
      check("r3_rs_data", rs_data, 32'hDEADBEEF);
      check("r3_rt_data", rt_data, 32'd0);

      // Write r4 while idle, then load-use hazard on rs=4
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_1234;
      tick();
      wb_en = 1'b0;
      ex_mem_read = 1'b1; ex_rt = 5'd4; in_valid = 1'b1; instruction = mk(5'd4, 5'd0, 16'h0000);
      #1;
      check("hazard_rs_in_ready", 32'(in_ready), 32'd0);
      instruction = mk(5'd0, 5'd4, 16'h0000);
      #1;
      check("hazard_rt_in_ready", 32'(in_ready), 32'd0);
      ex_rt = 5'd0; instruction = mk(5'd0, 5'd0, 16'h0000);
      #1;
      check("hazard_r0_in_ready", 32'(in_ready), 32'd1);
      ex_rt = 5'd4; instruction = mk(5'd4, 5'd0, 16'h0000);
      tick();
      check("hazard_no_accept", 32'(out_valid), 32'd0);
      ex_mem_read = 1'b0;
      #1;
      check("hazard_clear_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("hazard_accept_valid", 32'(out_valid), 32'd1);
      check("hazard_accept_rs", rs_data, 32'h0000_1234);
      held_rs = 32'h0000_1234;

      // Downstream stall for 3 cycles; write to r0 meanwhile
      out_ready = 1'b0; instruction = mk(5'd3, 5'd0, 16'h0000);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_rs_hold", rs_data, held_rs);
      end
      wb_en = 1'b0; out_ready = 1'b1; instruction = mk(5'd0, 5'd0, 16'h0000);
      #1;
      check("consume_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("consume_accept_valid", 32'(out_valid), 32'd1);
      check("r0_after_wb", rs_data, 32'd0);

      // Write-back to r7 in the same cycle as decode of rs=7
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0055; instruction = mk(5'd7, 5'd0, 16'h0000);
`ifdef DECODE_BYPASS_EN
      #1;
      check("bypass_in_ready", 32'(in_ready), 32'd1);
      tick();
      wb_en = 1'b0;
      check("bypass_rs_data", rs_data, 32'h0000_0055);
`else
      #1;
      check("wbconf_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("wbconf_bubble", 32'(out_valid), 32'd0);
      wb_en = 1'b0;
      #1;
      check("wbconf_release", 32'(in_ready), 32'd1);
      tick();
      check("wbconf_rs_data", rs_data, 32'h0000_0055);
`endif
      check("r7_out_valid", 32'(out_valid), 32'd1);

      // jal with signed immediate
      jal = 1'b1; imm_signed = 1'b1; pc_plus_4 = 32'h0000_0400; instruction = mk(5'd0, 5'd0, 16'h8000);
      tick();
      check("jal_dest", 32'(dest), 32'd31);
      check("jal_dest_we", 32'(dest_we), 32'd1);
      check("jal_link", link_data, 32'h0000_0400);
      check("imm_signed", imm_ext, 32'hFFFF_8000);

      // reg_dst selects rd (bits 15:11 of 0x8000 -> 16), unsigned immediate
      jal = 1'b0; imm_signed = 1'b0; reg_dst = 1'b1; reg_write = 1'b1;
      tick();
      check("rd_dest", 32'(dest), 32'd16);
      check("rd_dest_we", 32'(dest_we), 32'd1);
      check("imm_unsigned", imm_ext, 32'h0000_8000);

      // rt destination, no write
      reg_dst = 1'b0; reg_write = 1'b0; instruction = mk(5'd0, 5'd9, 16'h7FFF);
      imm_signed = 1'b1;
      tick();
      check("rt_dest", 32'(dest), 32'd9);
      check("rt_dest_we", 32'(dest_we), 32'd0);
      check("imm_pos_signed", imm_ext, 32'h0000_7FFF);

      // Reset aborts a held instruction and clears registers
      out_ready = 1'b0; instruction = mk(5'd3, 5'd0, 16'h0000);
      rst = 1'b0;
      tick();
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_dest", 32'(dest), 32'd0);
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; imm_signed = 1'b0;
      tick();
      check("cleared_r3", rs_data, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
